// File: rtl/shift_sequencer.sv
// Command-driven 8-bit pattern shift register with a prescaler and rotate/bounce modes.
// Accepts LOAD/RUN/STOP/STEP over valid/ready; out and tick_out are registered.
module shift_sequencer #(
  parameter int unsigned       WIDTH         = 8,
  parameter int unsigned       PRESCALE_W    = 16,
  parameter logic [WIDTH-1:0]  RESET_PATTERN = 8'h80
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_data,
  input  logic                  cfg_dir,
  input  logic                  cfg_mode,
  input  logic [PRESCALE_W-1:0] cfg_period,
  output logic [WIDTH-1:0]      out,
  output logic                  busy,
  output logic                  tick_out
);

  typedef enum logic [1:0] {StIdle, StRun, StStep} state_e;

  localparam logic [1:0] OpLoad = 2'd0;
  localparam logic [1:0] OpRun  = 2'd1;
  localparam logic [1:0] OpStop = 2'd2;
  localparam logic [1:0] OpStep = 2'd3;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        out_q, out_d;
  logic                    dir_q, dir_d;
  logic [PRESCALE_W-1:0]   cnt_q, cnt_d;
  logic                    tick_q, tick_d;

  logic [WIDTH-1:0]        shift_pat;
  logic                    shift_dir;
  logic                    accept;

  assign cmd_ready = (state_q != StStep);
  assign busy      = (state_q != StIdle);
  assign out       = out_q;
  assign tick_out  = tick_q;
  assign accept    = cmd_valid && cmd_ready;

  // Candidate pattern/direction if a shift happens this edge; mode is sampled live.
  always_comb begin
    shift_pat = out_q;
    shift_dir = dir_q;
    if (!cfg_mode) begin
      if (dir_q) shift_pat = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
      else       shift_pat = {out_q[0], out_q[WIDTH-1:1]};
    end else if (dir_q) begin
      if (out_q[WIDTH-1]) begin
        shift_dir = 1'b0;
        shift_pat = out_q >> 1;
      end else begin
        shift_pat = out_q << 1;
      end
    end else begin
      if (out_q[0]) begin
        shift_dir = 1'b1;
        shift_pat = out_q << 1;
      end else begin
        shift_pat = out_q >> 1;
      end
    end
  end

  // An accepted command always pre-empts a shift that is due on the same edge.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (accept) begin
      unique case (cmd_op)
        OpLoad: begin
          out_d = cmd_data;
          dir_d = cfg_dir;
          cnt_d = '0;
        end
        OpRun: begin
          state_d = StRun;
          dir_d   = cfg_dir;
          cnt_d   = '0;
        end
        OpStop: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
        OpStep: begin
          if (state_q == StIdle) state_d = StStep;
        end
        default: ;
      endcase
    end else if (state_q == StStep) begin
      out_d   = shift_pat;
      dir_d   = shift_dir;
      tick_d  = 1'b1;
      state_d = StIdle;
    end else if (state_q == StRun) begin
      if (cnt_q >= cfg_period) begin
        out_d  = shift_pat;
        dir_d  = shift_dir;
        tick_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      out_q   <= RESET_PATTERN;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed vector table, async-reset sequence, and
// randomized commands checked against a behavioural pattern model.
module tb_shift_sequencer;

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STOP = 2'd2;
  localparam logic [1:0] STEP = 2'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_data = 8'd0;
  logic        cfg_dir = 1'b0;
  logic        cfg_mode = 1'b0;
  logic [15:0] cfg_period = 16'd0;
  logic [7:0]  out;
  logic        busy;
  logic        tick_out;

  always #5 clock = ~clock;

  shift_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cfg_dir    (cfg_dir),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .out        (out),
    .busy       (busy),
    .tick_out   (tick_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: pattern held as an integer, shifts done with arithmetic.
  int   m_pat;
  logic m_dir, m_run, m_step, m_tick;
  int   m_elapsed;

  task automatic model_reset();
    m_pat = 128; m_dir = 0; m_run = 0; m_step = 0; m_tick = 0; m_elapsed = 0;
  endtask

  task automatic model_shift(input logic mode);
    if (!mode) begin
      if (m_dir) m_pat = (m_pat * 2) % 256 + m_pat / 128;
      else       m_pat = m_pat / 2 + (m_pat % 2) * 128;
    end else if (!m_dir) begin
      if (m_pat % 2 == 1) begin m_dir = 1; m_pat = (m_pat * 2) % 256; end
      else m_pat = m_pat / 2;
    end else begin
      if (m_pat >= 128) begin m_dir = 0; m_pat = m_pat / 2; end
      else m_pat = (m_pat * 2) % 256;
    end
    m_tick = 1;
  endtask

  task automatic model_edge(input logic v, input logic [1:0] op, input logic [7:0] d,
                            input logic dir, input logic mode, input int per);
    m_tick = 0;
    if (v && !m_step) begin
      case (op)
        LOAD: begin m_pat = int'(d); m_dir = dir; m_elapsed = 0; end
        RUN:  begin m_run = 1; m_dir = dir; m_elapsed = 0; end
        STOP: begin m_run = 0; m_elapsed = 0; end
        default: if (!m_run) m_step = 1;
      endcase
    end else if (m_step) begin
      model_shift(mode);
      m_step = 0;
    end else if (m_run) begin
      if (m_elapsed >= per) begin model_shift(mode); m_elapsed = 0; end
      else m_elapsed++;
    end
  endtask

  task automatic cycle(input logic v, input logic [1:0] op, input logic [7:0] d,
                       input logic dir, input logic mode, input logic [15:0] per);
    cmd_valid = v; cmd_op = op; cmd_data = d; cfg_dir = dir; cfg_mode = mode;
    cfg_period = per;
    @(posedge clock);
    model_edge(v, op, d, dir, mode, int'(per));
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " out"},   32'(out),       32'(m_pat));
    check({tag, " busy"},  32'(busy),      32'(m_run | m_step));
    check({tag, " tick"},  32'(tick_out),  32'(m_tick));
    check({tag, " ready"}, 32'(cmd_ready), 32'(!m_step));
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic [7:0]  d;
    logic        dir;
    logic        mode;
    logic [15:0] per;
    logic [7:0]  eo;
    logic        eb;
    logic        et;
    logic        er;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic v, input logic [1:0] op, input logic [7:0] d,
                     input logic dir, input logic mode, input logic [15:0] per,
                     input logic [7:0] eo, input logic eb, input logic et, input logic er);
    vec_t x;
    x.v = v; x.op = op; x.d = d; x.dir = dir; x.mode = mode; x.per = per;
    x.eo = eo; x.eb = eb; x.et = et; x.er = er;
    vt.push_back(x);
  endtask

  logic [7:0] rot_seq[8]    = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
  logic [7:0] bounce_seq[9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40};

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset out",   32'(out),       32'h80);
    check("reset busy",  32'(busy),      32'h0);
    check("reset tick",  32'(tick_out),  32'h0);
    check("reset ready", 32'(cmd_ready), 32'h1);
    reset = 1'b1;

    // Rotate right, period 0
    add(1, RUN, 8'h00, 0, 0, 16'd0, 8'h80, 1, 0, 1);
    for (int i = 0; i < 8; i++) add(0, LOAD, 8'h00, 0, 0, 16'd0, rot_seq[i], 1, 1, 1);
    // Rotate left, period 3
    add(1, LOAD, 8'h81, 1, 0, 16'd3, 8'h81, 1, 0, 1);
    add(1, RUN,  8'h00, 1, 0, 16'd3, 8'h81, 1, 0, 1);
    for (int k = 1; k <= 8; k++)
      add(0, LOAD, 8'h00, 0, 0, 16'd3, (k < 4) ? 8'h81 : (k < 8) ? 8'h03 : 8'h06, 1,
          (k % 4) == 0, 1);
    add(1, STOP, 8'h00, 0, 0, 16'd3, 8'h06, 0, 0, 1);
    // Bounce from 02 heading right
    add(1, LOAD, 8'h02, 0, 1, 16'd0, 8'h02, 0, 0, 1);
    add(1, RUN,  8'h00, 0, 1, 16'd0, 8'h02, 1, 0, 1);
    for (int i = 0; i < 9; i++) add(0, LOAD, 8'h00, 0, 1, 16'd0, bounce_seq[i], 1, 1, 1);
    add(1, STOP, 8'h00, 0, 1, 16'd0, 8'h40, 0, 0, 1);
    // STEP, with a second STEP held while not ready
    add(1, LOAD, 8'h80, 0, 0, 16'd0, 8'h80, 0, 0, 1);
    add(1, STEP, 8'h00, 0, 0, 16'd0, 8'h80, 1, 0, 0);
    add(1, STEP, 8'h00, 0, 0, 16'd0, 8'h40, 0, 1, 1);
    add(1, STEP, 8'h00, 0, 0, 16'd0, 8'h40, 1, 0, 0);
    add(0, STEP, 8'h00, 0, 0, 16'd0, 8'h20, 0, 1, 1);
    // LOAD on a due-shift cycle wins, then STOP holds
    add(1, RUN,  8'h00, 0, 0, 16'd0, 8'h20, 1, 0, 1);
    add(0, LOAD, 8'h00, 0, 0, 16'd0, 8'h10, 1, 1, 1);
    add(1, LOAD, 8'hF0, 0, 0, 16'd0, 8'hF0, 1, 0, 1);
    add(0, LOAD, 8'h00, 0, 0, 16'd0, 8'h78, 1, 1, 1);
    add(1, STOP, 8'h00, 0, 0, 16'd0, 8'h78, 0, 0, 1);
    add(0, LOAD, 8'h00, 0, 0, 16'd0, 8'h78, 0, 0, 1);

    foreach (vt[i]) begin
      cycle(vt[i].v, vt[i].op, vt[i].d, vt[i].dir, vt[i].mode, vt[i].per);
      check($sformatf("vec%0d out", i),   32'(out),       32'(vt[i].eo));
      check($sformatf("vec%0d busy", i),  32'(busy),      32'(vt[i].eb));
      check($sformatf("vec%0d tick", i),  32'(tick_out),  32'(vt[i].et));
      check($sformatf("vec%0d ready", i), 32'(cmd_ready), 32'(vt[i].er));
    end

    // Asynchronous reset between edges while running
    cycle(1, RUN, 8'h00, 0, 0, 16'd0);
    cycle(0, LOAD, 8'h00, 0, 0, 16'd0);
    cycle(0, LOAD, 8'h00, 0, 0, 16'd0);
    check("pre-reset out", 32'(out), 32'h1E);
    #3;
    reset = 1'b0;
    #1;
    check("async out",   32'(out),      32'h80);
    check("async busy",  32'(busy),     32'h0);
    check("async tick",  32'(tick_out), 32'h0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(0, LOAD, 8'h00, 0, 0, 16'd0);
      check($sformatf("post-reset%0d out", i),  32'(out),      32'h80);
      check($sformatf("post-reset%0d tick", i), 32'(tick_out), 32'h0);
      check($sformatf("post-reset%0d busy", i), 32'(busy),     32'h0);
    end

    // Randomized commands against the model
    begin
      logic [15:0] per;
      per = 16'd2;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 49) == 0) per = 16'($urandom_range(0, 6));
        cycle($urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)), 8'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), per);
        check_model($sformatf("rand%0d", n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Controller that owns and sequences an 8-bit pattern shift register. It accepts LOAD/RUN/STOP/STEP commands over a valid/ready handshake. A programmable prescaler paces the shifts, and the block supports rotate and bounce modes in either direction. Its output drives LED/pattern datapaths directly, replacing free-running circular shifters that shift on every clock.

Parameters:
WIDTH, 8, pattern width in bits (min 2)
PRESCALE_W, 16, width of the period counter and cfg_period
RESET_PATTERN, 8'h80, pattern loaded by reset (WIDTH bits)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  reset is asynchronous and active-low (0 = reset)
cmd_valid  input  1  command present
cmd_ready  output  1  command can be accepted this cycle
cmd_op  input  2  0=LOAD, 1=RUN, 2=STOP, 3=STEP
cmd_data  input  WIDTH  pattern for LOAD; ignored otherwise
cfg_dir  input  1  0=right (toward bit 0), 1=left
cfg_mode  input  1  0=rotate, 1=bounce
cfg_period  input  PRESCALE_W  shift every cfg_period+1 cycles while running
out  output  WIDTH  current pattern, registered
busy  output  1  1 while in RUN or STEP
tick_out  output  1  one-cycle pulse in the cycle after each shift

Behaviour:
- Reset (reset=0, asynchronous): out=RESET_PATTERN, state=IDLE, dir_r=0, prescaler cnt=0, tick_out=0, busy=0, cmd_ready=1. Reset mid-run aborts immediately; no partial shift.
- States: IDLE, RUN, STEP. busy=(state!=IDLE). cmd_ready=(state!=STEP).
- Handshake: a command is accepted on a rising edge with cmd_valid&&cmd_ready and takes effect on that edge. cmd_valid while cmd_ready=0 is not consumed; the requester holds it.
- LOAD: out<=cmd_data, dir_r<=cfg_dir, cnt<=0. State unchanged.
- RUN: state<=RUN, dir_r<=cfg_dir, cnt<=0. The first shift occurs on edge N+cfg_period+1, where N is the accept edge.
- STOP: state<=IDLE, cnt<=0, out holds. Legal (no-op) in IDLE.
- STEP in IDLE: state<=STEP. The next edge performs exactly one shift and returns to IDLE. STEP in RUN is accepted with no effect.
- Prescaler in RUN: if cnt>=cfg_period, then shift, cnt<=0. Otherwise cnt<=cnt+1. The compare uses the live cfg_period, so a shrinking period never stalls. cfg_period=0 shifts every cycle.
- Command accepted in the same cycle as a due shift: the command wins and no shift occurs that edge.
- Shift function (applies to both RUN and STEP):
  - Rotate, dir_r=0: out<={out[0],out[W-1:1]}.
  - Rotate, dir_r=1: out<={out[W-2:0],out[W-1]}.
  - Bounce, dir_r=0: if out[0]=1, then dir_r<=1 and shift left (zero fill); else shift right (zero fill).
  - Bounce, dir_r=1: if out[W-1]=1, then dir_r<=0 and shift right; else shift left.
  - All-zero pattern stays zero in every mode.
  - cfg_mode is sampled at each shift. cfg_dir is sampled only on LOAD/RUN.
- tick_out: registered. It is 1 for exactly one cycle following every shift edge and 0 otherwise, including after commands.

Test Plan:
- Reset then RUN, cfg_mode=0, cfg_dir=0, cfg_period=0 -> out steps 80,40,20,10,08,04,02,01,80 on consecutive edges; tick_out high every cycle; busy=1.
- LOAD 8'h81, RUN, rotate left, cfg_period=3 -> out 81->03->06, one shift per 4 cycles; tick_out high 1 of every 4 cycles.
- LOAD 8'h02, bounce, cfg_dir=0, cfg_period=0 -> out 02,01,02,04,...,80,40 (reversal at both ends).
- IDLE, STEP with out=8'h80 rotate right -> cmd_ready=0 for one cycle, out=8'h40, state back to IDLE, busy pulse for 1 cycle; a second STEP issued while cmd_ready=0 is held and executes next -> 8'h20.
- RUN with cfg_period=0, then issue LOAD 8'hF0 on a due-shift cycle -> out=F0 on that edge (no shift), next edge 78. Then STOP -> out holds at 78, tick_out=0.
- Assert reset low mid-RUN between edges -> out=80, busy=0, tick_out=0 immediately (asynchronously); after release, no shifting until RUN.
